// File: rtl/pc_pkg.sv
// pc_pkg: shared encodings and helpers for the program-counter unit.
//   br_cond_e : branch-condition modes (BR_EQ, BR_NE, BR_LT, BR_GE)
//   pc_src_e  : next-PC source select (SRC_SEQ, SRC_BR, SRC_JMP, SRC_RET)
//   branch_cond() : evaluates a branch mode against the ALU flags.
package pc_pkg;

    typedef enum logic [1:0] {
        BR_EQ = 2'b00,
        BR_NE = 2'b01,
        BR_LT = 2'b10,
        BR_GE = 2'b11
    } br_cond_e;

    typedef enum logic [1:0] {
        SRC_SEQ = 2'b00,
        SRC_BR  = 2'b01,
        SRC_JMP = 2'b10,
        SRC_RET = 2'b11
    } pc_src_e;

    function automatic logic branch_cond(input logic [1:0] br_cond,
                                         input logic       zero,
                                         input logic       neg);
        case (br_cond)
            BR_EQ:   return zero;
            BR_NE:   return ~zero;
            BR_LT:   return neg;
            default: return ~neg;
        endcase
    endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack (LIFO).
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : store push_data as the new top entry
//   pop         : discard the top entry
//   push_data   : address to store
//   top         : current top entry (valid when !empty)
//   empty, full : occupancy decodes of the registered count
//   err         : sticky overflow/underflow flag, cleared only by reset
// push and pop together replace the top entry in place. On an empty stack
// that combination flags an underflow and still stores one entry.
// Overflowing a full stack overwrites the oldest entry: when full, the
// next-free pointer has wrapped onto the oldest slot.
module pc_ras
    import pc_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             err
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] mem [RAS_DEPTH];

    logic [PTR_W-1:0] sp_reg, sp_next;     // next free slot
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             err_reg, err_next;
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W-1:0] wr_idx;
    logic             wr_en;

    assign top_idx = sp_reg - PTR_W'(1);
    assign top     = mem[top_idx];
    assign empty   = (cnt_reg == '0);
    assign full    = (cnt_reg == CNT_MAX);
    assign err     = err_reg;

    always_comb begin
        sp_next  = sp_reg;
        cnt_next = cnt_reg;
        err_next = err_reg;
        wr_en    = 1'b0;
        wr_idx   = sp_reg;
        if (push && pop) begin
            wr_en = 1'b1;
            if (empty) begin
                err_next = 1'b1;
                sp_next  = sp_reg + PTR_W'(1);
                cnt_next = CNT_W'(1);
            end else begin
                wr_idx = top_idx;
            end
        end else if (push) begin
            wr_en   = 1'b1;
            sp_next = sp_reg + PTR_W'(1);
            if (full) begin
                err_next = 1'b1;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end else if (pop) begin
            if (empty) begin
                err_next = 1'b1;
            end else begin
                sp_next  = top_idx;
                cnt_next = cnt_reg - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_reg  <= '0;
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            sp_reg  <= sp_next;
            cnt_reg <= cnt_next;
            err_reg <= err_next;
        end
    end

    // Entry storage needs no reset; contents are meaningless while count is 0.
    always_ff @(posedge clk) begin
        if (wr_en && rst_n) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with branch/jump/return next-PC selection.
//   CLK, reset          : clock, asynchronous active-low reset
//   PCWrite             : unconditional update
//   Stall               : freezes PC and RAS (highest priority after reset)
//   Branch, BrCond      : conditional update and its mode
//   Zero, Neg           : ALU flags
//   PCSrc               : next-PC source (seq / branch / jump / return)
//   Call                : push PCInA on the return-address stack
//   PCInA, PCInB, PCInC : candidate next-PC values
//   PCOut               : current PC (registered)
//   RasEmpty, RasFull   : stack occupancy
//   RasErr              : sticky stack overflow/underflow
// Build option: define PC_RAS_EN to build the return-address stack.
// Without it, a return selects address 0, Call is ignored and the stack
// status outputs are tied to empty / not full / no error.
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             PCWrite,
    input  logic             Stall,
    input  logic             Branch,
    input  logic [1:0]       BrCond,
    input  logic             Zero,
    input  logic             Neg,
    input  logic [1:0]       PCSrc,
    input  logic             Call,
    input  logic [WIDTH-1:0] PCInA,
    input  logic [WIDTH-1:0] PCInB,
    input  logic [WIDTH-1:0] PCInC,
    output logic [WIDTH-1:0] PCOut,
    output logic             RasEmpty,
    output logic             RasFull,
    output logic             RasErr
);

    logic             take;
    logic             upd;
    logic [WIDTH-1:0] ret_pc;
    logic [WIDTH-1:0] pc_reg, pc_next;

    assign take = Branch & branch_cond(BrCond, Zero, Neg);
    assign upd  = ~Stall & (PCWrite | take);

`ifdef PC_RAS_EN
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty;

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (CLK),
        .rst_n     (reset),
        .push      (upd & Call),
        .pop       (upd & (PCSrc == SRC_RET)),
        .push_data (PCInA),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (RasFull),
        .err       (RasErr)
    );

    assign RasEmpty = ras_empty;
    // Returning from an empty stack restarts at the reset vector.
    assign ret_pc   = ras_empty ? RESET_VEC : ras_top;
`else
    logic unused_call;
    assign unused_call = Call;
    assign ret_pc      = '0;
    assign RasEmpty    = 1'b1;
    assign RasFull     = 1'b0;
    assign RasErr      = 1'b0;
`endif

    always_comb begin
        pc_next = pc_reg;
        if (upd) begin
            case (PCSrc)
                SRC_SEQ: pc_next = PCInA;
                SRC_BR:  pc_next = PCInB;
                SRC_JMP: pc_next = PCInC;
                default: pc_next = ret_pc;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            pc_reg <= RESET_VEC;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign PCOut = pc_reg;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit. A behavioural model (queue-based stack)
// computes the expected state for each driven cycle and pushes it to a
// scoreboard queue; after the clock edge the entry is popped and compared.
module tb_pc_unit;

    localparam int          W     = 16;
    localparam int          DEPTH = 4;
    localparam logic [15:0] RVEC  = 16'h0F00;
`ifdef PC_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] pc;
        logic        empty;
        logic        full;
        logic        err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pc_write, stall, branch, zero, neg, call;
    logic [1:0]    br_cond, pc_src;
    logic [W-1:0]  in_a, in_b, in_c;
    logic [W-1:0]  pc_out;
    logic          ras_empty, ras_full, ras_err;

    int total = 0;
    int bad   = 0;

    exp_t        exp_q[$];
    logic [15:0] m_stk[$];
    logic [15:0] m_pc;
    logic        m_err;

    always #5 clk = ~clk;

    pc_unit #(
        .WIDTH     (W),
        .RAS_DEPTH (DEPTH),
        .RESET_VEC (RVEC)
    ) dut (
        .CLK      (clk),
        .reset    (rst_n),
        .PCWrite  (pc_write),
        .Stall    (stall),
        .Branch   (branch),
        .BrCond   (br_cond),
        .Zero     (zero),
        .Neg      (neg),
        .PCSrc    (pc_src),
        .Call     (call),
        .PCInA    (in_a),
        .PCInB    (in_b),
        .PCInC    (in_c),
        .PCOut    (pc_out),
        .RasEmpty (ras_empty),
        .RasFull  (ras_full),
        .RasErr   (ras_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    task automatic check_state(input string tag, input exp_t e);
        check({tag, ".pc"},    32'(pc_out),    32'(e.pc));
        check({tag, ".empty"}, 32'(ras_empty), 32'(e.empty));
        check({tag, ".full"},  32'(ras_full),  32'(e.full));
        check({tag, ".err"},   32'(ras_err),   32'(e.err));
    endtask

    function automatic exp_t model_state();
        exp_t e;
        e.pc    = m_pc;
        e.empty = RAS_EN ? (m_stk.size() == 0) : 1'b1;
        e.full  = RAS_EN ? (m_stk.size() == DEPTH) : 1'b0;
        e.err   = RAS_EN ? m_err : 1'b0;
        return e;
    endfunction

    task automatic idle();
        pc_write = 0; stall = 0; branch = 0; br_cond = 0; zero = 0; neg = 0;
        pc_src = 0; call = 0;
    endtask

    // Apply the currently driven inputs for one clock, via the scoreboard.
    task automatic step(input string tag);
        logic cond, upd;
        exp_t e;
        case (br_cond)
            2'b00:   cond = zero;
            2'b01:   cond = !zero;
            2'b10:   cond = neg;
            default: cond = !neg;
        endcase
        upd = !stall && (pc_write || (branch && cond));
        if (upd) begin
            case (pc_src)
                2'b00: m_pc = in_a;
                2'b01: m_pc = in_b;
                2'b10: m_pc = in_c;
                default: begin
                    if (!RAS_EN)                m_pc = 16'h0000;
                    else if (m_stk.size() == 0) m_pc = RVEC;
                    else                        m_pc = m_stk[m_stk.size()-1];
                end
            endcase
            if (RAS_EN) begin
                if (pc_src == 2'b11 && call) begin
                    if (m_stk.size() == 0) begin
                        m_err = 1'b1;
                        m_stk.push_back(in_a);
                    end else begin
                        m_stk[m_stk.size()-1] = in_a;
                    end
                end else if (pc_src == 2'b11) begin
                    if (m_stk.size() == 0) m_err = 1'b1;
                    else void'(m_stk.pop_back());
                end else if (call) begin
                    if (m_stk.size() == DEPTH) begin
                        void'(m_stk.pop_front());
                        m_err = 1'b1;
                    end
                    m_stk.push_back(in_a);
                end
            end
        end
        exp_q.push_back(model_state());
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        $display("txn %-10s wr=%0b st=%0b br=%0b c=%0d src=%0d call=%0b -> pc=%h e=%0b f=%0b err=%0b",
                 tag, pc_write, stall, branch, br_cond, pc_src, call, pc_out, ras_empty, ras_full, ras_err);
        check_state(tag, e);
    endtask

    task automatic do_call(input logic [15:0] ret_addr, input string tag);
        idle(); pc_write = 1; call = 1; pc_src = 2'b10; in_a = ret_addr; in_c = 16'h0200;
        step(tag);
    endtask

    task automatic do_ret(input string tag);
        idle(); pc_write = 1; pc_src = 2'b11;
        step(tag);
    endtask

    initial begin
        idle();
        in_a = 0; in_b = 0; in_c = 0;
        rst_n = 0;
        m_pc = RVEC; m_err = 0;
        #12;
        check_state("reset", model_state());
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // sequential
        idle(); pc_write = 1; pc_src = 2'b00; in_a = 16'h0001;
        step("seq");

        // bne not taken / taken, blt taken
        idle(); branch = 1; br_cond = 2'b01; zero = 1; pc_src = 2'b01; in_b = 16'h0040;
        step("bne_nt");
        zero = 0;
        step("bne_t");
        br_cond = 2'b10; neg = 1; in_b = 16'h0050;
        step("blt_t");
        br_cond = 2'b11;
        step("bge_nt");

        // stall overrides write and call
        idle(); stall = 1; pc_write = 1; call = 1; in_a = 16'h0077;
        step("stall");

        // nested call/return
        do_call(16'h0011, "call1");
        do_call(16'h0022, "call2");
        do_ret("ret2");
        do_ret("ret1");

        // async reset with two entries on the stack
        do_call(16'h0033, "call3");
        do_call(16'h0044, "call4");
        idle();
        #2;
        rst_n = 0;
        #1;
        m_pc = RVEC; m_err = 0; m_stk.delete();
        check_state("async_rst", model_state());
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // overflow then drain past empty
        for (int i = 1; i <= 5; i++) do_call(16'h0100 + 16'(i), "ovf_call");
        for (int i = 0; i < 5; i++) do_ret("ovf_ret");

        // return+call on an empty stack
        idle(); pc_write = 1; pc_src = 2'b11; call = 1; in_a = 16'h0555;
        step("retcall");

        // random mix
        for (int i = 0; i < 60; i++) begin
            pc_write = ($urandom_range(0, 2) == 0);
            stall    = ($urandom_range(0, 4) == 0);
            branch   = $urandom_range(0, 1);
            br_cond  = 2'($urandom_range(0, 3));
            zero     = $urandom_range(0, 1);
            neg      = $urandom_range(0, 1);
            pc_src   = 2'($urandom_range(0, 3));
            call     = ($urandom_range(0, 2) == 0);
            in_a     = 16'($urandom);
            in_b     = 16'($urandom);
            in_c     = 16'($urandom);
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
